// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the RV32I core blocks.
//   seq_state_t : sequencer state encoding (BOOT, FETCH, DECODE, EXEC, WB, HALT)
//   INSTR_NOP   : addi x0,x0,0, the instruction register value after reset
//   XLEN        : architectural data width
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer for the RV32I core.
// Owns the PC and instruction register, fetches over a req/ack handshake and
// walks each instruction through DECODE, EXEC and WB so the combinational
// decoder and ALU see stable inputs. Write strobes from the decoder are gated
// to the single WB cycle. Counts retired instructions, supports halt/resume
// and flags a sticky fetch timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req / imem_addr     fetch request and word address (addr == pc)
//   imem_ack / imem_rdata    fetch completion and instruction word
//   instr                    instruction register
//   regwrite_dec/gpio_we_dec decoder strobes
//   regwrite_en/gpio_we_en   strobes gated to WB
//   jump_valid/jump_target   redirect, sampled in EXEC
//   halt_req                 sampled in WB
//   resume                   sampled in HALT
//   pc, instret              current PC, retired-instruction count
//   halted, fault            in HALT, sticky fetch-timeout flag
//   state                    current sequencer state (debug visibility)
//
// Fetch handshake: imem_req is high for every FETCH cycle and imem_addr is
// stable while it is high. A cycle with imem_req and imem_ack both high
// transfers imem_rdata into instr. imem_ack while imem_req is low is ignored.
module core_sequencer
  import core_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   instr,
  input  logic              regwrite_dec,
  input  logic              gpio_we_dec,
  output logic              regwrite_en,
  output logic              gpio_we_en,
  input  logic              jump_valid,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [PC_W-1:0]   pc,
  output logic [XLEN-1:0]   instret,
  output logic              halted,
  output logic              fault,
  output seq_state_t        state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instret_q;
  logic            fault_q;
  logic [CNT_W-1:0] cnt_q;
  logic            jump_pend_q;
  logic [PC_W-1:0] jump_tgt_q;

  // The counter holds the number of ack-less FETCH cycles already seen, so
  // timeout fires in the (TIMEOUT+1)-th FETCH cycle. An ack always wins.
  logic timeout_hit;
  assign timeout_hit = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH: begin
        if (imem_ack)         state_d = DECODE;
        else if (timeout_hit) state_d = HALT;
      end
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = halt_req ? HALT : FETCH;
      HALT: begin
        // A faulted core leaves HALT only through reset.
        if (resume && !fault_q) state_d = FETCH;
      end
      default: state_d = BOOT;
    endcase
  end

  // Strobes decode the state register only; the decoder strobes are the
  // sole inputs allowed to reach an output combinationally.
  always_comb begin
    imem_req    = (state_q == FETCH);
    regwrite_en = (state_q == WB) && regwrite_dec;
    gpio_we_en  = (state_q == WB) && gpio_we_dec;
    halted      = (state_q == HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= INSTR_NOP;
      instret_q   <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
      jump_pend_q <= 1'b0;
      jump_tgt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        EXEC: begin
          if (jump_valid) begin
            jump_pend_q <= 1'b1;
            jump_tgt_q  <= jump_target;
          end
        end
        WB: begin
          pc_q        <= jump_pend_q ? jump_tgt_q : pc_q + 1'b1;
          jump_pend_q <= 1'b0;
          instret_q   <= instret_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule
